// File: rtl/pipeline_flow_ctrl_pkg.sv
// ============================================================================
// Module  : pipeline_flow_ctrl_pkg
// Brief   : Shared op codes and wait-FSM state encodings for the flow control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_flow_ctrl_pkg;

  typedef logic [1:0] stage_op_t;

  localparam stage_op_t NORMAL_OP = 2'b00;
  localparam stage_op_t PAUSE_OP  = 2'b01;
  localparam stage_op_t RST_OP    = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_e;

endpackage : pipeline_flow_ctrl_pkg

`default_nettype wire

// File: rtl/flow_wait_counter.sv
// ============================================================================
// Module  : flow_wait_counter
// Brief   : Multi-cycle wait FSM: accepts wait requests, counts stall cycles,
//           latches the stalling stage and honours flush cancellation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flow_wait_counter
  import pipeline_flow_ctrl_pkg::*;
#(
  parameter int STAGES = 5,
  parameter int CNT_W  = 4,
  parameter int SW     = $clog2(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wait_req_i,
  input  logic [SW-1:0]    wait_stage_i,
  input  logic [CNT_W-1:0] wait_cycles_i,
  input  logic             cancel_i,
  output logic             wait_accept_o,
  output logic             wait_active_o,
  output logic [SW-1:0]    wait_stage_o
);

  wait_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [SW-1:0]    stage_in;

  // Stage 0 is the PC and cannot wait; out-of-range indices clamp to the last stage.
  always_comb begin
    if (wait_stage_i == '0) begin
      stage_in = SW'(1);
    end else if (int'(wait_stage_i) >= STAGES) begin
      stage_in = SW'(STAGES - 1);
    end else begin
      stage_in = wait_stage_i;
    end
  end

  // Outputs kept apart from next-state so cancel_i never loops back into them.
  always_comb begin
    wait_accept_o = 1'b0;
    wait_active_o = 1'b0;
    wait_stage_o  = stage_q;
    if (!rst) begin
      if (state_q == ST_WAIT) begin
        wait_active_o = 1'b1;
      end else if (wait_req_i) begin
        wait_accept_o = 1'b1;
        if (wait_cycles_i != '0) begin
          wait_active_o = 1'b1;
          wait_stage_o  = stage_in;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    case (state_q)
      ST_IDLE: begin
        if (wait_req_i && (wait_cycles_i > CNT_W'(1)) && !cancel_i) begin
          state_d = ST_WAIT;
          cnt_d   = wait_cycles_i - CNT_W'(1);
          stage_d = stage_in;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
        if (cancel_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

endmodule : flow_wait_counter

`default_nettype wire

// File: rtl/pipeline_flow_ctrl.sv
// ============================================================================
// Module  : pipeline_flow_ctrl
// Brief   : Pipeline hazard controller producing a per-register op from stall,
//           wait and flush requests. Optional perf counters: FLOW_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_flow_ctrl
  import pipeline_flow_ctrl_pkg::*;
#(
  parameter  int STAGES = 5,
  parameter  int CNT_W  = 4,
  localparam int SW     = $clog2(STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STAGES-1:0]     StallReq_i,
  input  logic                  WaitReq_i,
  input  logic [SW-1:0]         WaitStage_i,
  input  logic [CNT_W-1:0]      WaitCycles_i,
  output logic                  WaitAccept_o,
  input  logic                  FlushReq_i,
  input  logic [SW-1:0]         FlushStage_i,
  output logic [2*STAGES-1:0]   StageOp_o,
  output logic                  Busy_o
`ifdef FLOW_PERF_CNT_EN
  ,
  output logic [31:0]           StallCycles_o,
  output logic [15:0]           FlushCount_o
`endif
);

  logic [STAGES-1:0] stall_vec;
  logic              wait_active, wait_cancel;
  logic [SW-1:0]     wait_stage;
  logic              s_present;
  logic [SW-1:0]     s_idx;
  logic              req_flush_ok, f_valid, flush_apply, flush_blocked;
  logic [SW-1:0]     f_stage;
  logic              pf_valid_q, pf_valid_d;
  logic [SW-1:0]     pf_stage_q, pf_stage_d;
  logic              unused_stall0;

  assign unused_stall0 = StallReq_i[0];

  flow_wait_counter #(
    .STAGES (STAGES),
    .CNT_W  (CNT_W),
    .SW     (SW)
  ) u_wait (
    .clk           (clk),
    .rst           (rst),
    .wait_req_i    (WaitReq_i),
    .wait_stage_i  (WaitStage_i),
    .wait_cycles_i (WaitCycles_i),
    .cancel_i      (wait_cancel),
    .wait_accept_o (WaitAccept_o),
    .wait_active_o (wait_active),
    .wait_stage_o  (wait_stage)
  );

  // Effective stall stage: the oldest (highest-index) stage asking to hold.
  always_comb begin
    stall_vec = {StallReq_i[STAGES-1:1], 1'b0};
    if (wait_active) begin
      stall_vec = stall_vec | (STAGES'(1) << wait_stage);
    end
    s_present = 1'b0;
    s_idx     = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stall_vec[k]) begin
        s_present = 1'b1;
        s_idx     = SW'(k);
      end
    end
  end

  // A pending flush competes like a live one; the older (higher) stage wins.
  always_comb begin
    req_flush_ok = FlushReq_i && (FlushStage_i != '0) && (int'(FlushStage_i) < STAGES);
    f_valid      = req_flush_ok || pf_valid_q;
    f_stage      = pf_stage_q;
    if (req_flush_ok && (!pf_valid_q || (FlushStage_i > pf_stage_q))) begin
      f_stage = FlushStage_i;
    end
    flush_apply   = f_valid && (!s_present || (s_idx < f_stage));
    flush_blocked = f_valid && !flush_apply;
    wait_cancel   = flush_apply;
  end

  always_comb begin
    pf_valid_d = pf_valid_q;
    pf_stage_d = pf_stage_q;
    if (flush_apply) begin
      pf_valid_d = 1'b0;
      pf_stage_d = '0;
    end else if (flush_blocked) begin
      pf_valid_d = 1'b1;
      pf_stage_d = f_stage;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_valid_q <= 1'b0;
      pf_stage_q <= '0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_stage_q <= pf_stage_d;
    end
  end

  always_comb begin
    StageOp_o = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (rst) begin
        StageOp_o[2*k +: 2] = RST_OP;
      end else if (flush_apply) begin
        StageOp_o[2*k +: 2] = ((k != 0) && (k <= int'(f_stage))) ? RST_OP : NORMAL_OP;
      end else if (s_present) begin
        if (k <= int'(s_idx)) begin
          StageOp_o[2*k +: 2] = PAUSE_OP;
        end else if (k == int'(s_idx) + 1) begin
          StageOp_o[2*k +: 2] = RST_OP;
        end else begin
          StageOp_o[2*k +: 2] = NORMAL_OP;
        end
      end else begin
        StageOp_o[2*k +: 2] = NORMAL_OP;
      end
    end
  end

  assign Busy_o = !rst && (wait_active || flush_blocked);

`ifdef FLOW_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (s_present && !flush_apply && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (flush_apply && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign StallCycles_o = stall_cycles_q;
  assign FlushCount_o  = flush_count_q;
`endif

endmodule : pipeline_flow_ctrl

`default_nettype wire

// File: doc/pipeline_flow_ctrl.md
Name: pipeline_flow_ctrl

Overview:
- Parametrised pipeline hazard controller for the CPU32 core.
- Turns per-stage stall requests, multi-cycle wait requests and redirect/flush requests into one 2-bit op per pipeline register: PC is register 0, IF/ID is register 1, and so on.
- Adds sequential behaviour: a wait-state counter and a pending-flush latch that holds a flush blocked by an older stall.

Parameters:
- STAGES, 5, number of pipeline registers including PC (minimum 3).
- CNT_W, 4, width of the wait-cycle counter.
- SW, $clog2(STAGES) (localparam), width of a stage index.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- StallReq_i  in  STAGES  bit k=1: stage k (fed by register k) cannot advance. Bit 0 is ignored.
- WaitReq_i  in  1  one-cycle pulse that starts a multi-cycle stall.
- WaitStage_i  in  SW  stage index for the wait.
- WaitCycles_i  in  CNT_W  number of stall cycles N.
- WaitAccept_o  out  1  the wait request was accepted this cycle.
- FlushReq_i  in  1  stage FlushStage_i redirects; all younger instructions die.
- FlushStage_i  in  SW  flushing stage f, 1..STAGES-1.
- StageOp_o  out  2*STAGES  op for register k in bits [2k+1:2k]. Codes are NORMAL_OP, PAUSE_OP, RST_OP.
- Busy_o  out  1  wait active or flush pending.

Behaviour:
- Effective stall stage S = highest k with an active stall, or none. A stall is active if StallReq_i[k]=1, or if a wait is active at stage k.
- Stall rule, when S exists:
  - registers 0..S get PAUSE_OP;
  - register S+1 gets RST_OP (bubble), if S+1 < STAGES;
  - higher registers get NORMAL_OP.
- Flush rule for stage f:
  - register 0 gets NORMAL_OP (PC loads the redirect target);
  - registers 1..f get RST_OP;
  - registers above f get NORMAL_OP.
- Priority:
  - If S ≥ f, the stall wins. The flush is latched into the pending flush register (PF valid plus stage), and outputs follow the stall rule.
  - If S < f, or there is no stall, the flush wins. An active wait at a stage < f is cancelled: counter cleared, state returns to IDLE.
  - A pending flush is re-evaluated every cycle exactly as if FlushReq_i were high with the latched stage. It is cleared in the cycle it is applied.
  - A new FlushReq_i while PF is valid overwrites PF only if its stage is higher (older).
- State machine:
  - IDLE: WaitReq_i with N>0 → accepted (WaitAccept_o=1). The stall applies combinationally in that same cycle. Counter loads N-1 and state goes to WAIT if N>1; with N=1 it stays IDLE. WaitReq_i with N=0 is accepted with no stall.
  - WAIT: stall active at the latched stage. Counter decrements each cycle; at 0 → IDLE after that cycle. Total stall length is exactly N cycles. WaitReq_i is ignored (WaitAccept_o=0).
  - PF is an independent flag, not a state.
- Input checks: FlushStage_i=0 or ≥ STAGES is ignored. WaitStage_i=0 is treated as 1.
- Reset: while rst=1, StageOp_o is all RST_OP, WaitAccept_o=0 and Busy_o=0. The counter, wait stage and PF are cleared on the clock edge.
- With no requests, all registers get NORMAL_OP.
- Outputs are combinational from registered state plus current inputs; there is zero-cycle latency from any request to StageOp_o.

Optional Feature:
- Macro: FLOW_PERF_CNT_EN.
- Defined:
  - adds StallCycles_o (32-bit): counts cycles with S present;
  - adds FlushCount_o (16-bit): counts applied flushes;
  - both saturate and are cleared by rst.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines file holds NORMAL_OP, PAUSE_OP, RST_OP, and the WAIT/IDLE state encodings.
- Natural sub-module: flow_wait_counter, which holds the wait FSM, counter, latched stage and the accept/cancel logic.
- Priority resolution and per-register op generation stay in the top module.

Test Plan (STAGES=5):
- StallReq_i=5'b00010 → registers 0,1 PAUSE_OP, register 2 RST_OP, registers 3,4 NORMAL_OP.
- WaitReq_i at stage 3 with N=3 → registers 0–3 PAUSE_OP and register 4 RST_OP for exactly 3 cycles. WaitAccept_o pulses once. A second WaitReq_i in cycle 2 is ignored.
- FlushReq_i f=2 while StallReq_i[3]=1 for 2 cycles → stall outputs and Busy_o=1. In the cycle StallReq_i drops: register 0 NORMAL_OP, registers 1,2 RST_OP, registers 3,4 NORMAL_OP, then Busy_o=0.
- FlushReq_i f=3 during a wait at stage 2 → flush outputs immediately; the wait is cancelled; all registers NORMAL_OP in the next cycle.
- rst asserted mid-WAIT with PF valid → all registers RST_OP. After rst drops, all registers NORMAL_OP and Busy_o=0.
- WaitReq_i with N=0 → WaitAccept_o=1, no stall, all registers NORMAL_OP.
